dmem_ctrl: RTL and testbench

Parametrised data-memory controller for the RISC-V core family. It is the next-generation replacement for the fixed single-cycle word data memory. It adds a request/ready handshake with configurable wait states, so multicycle and pipelined cores can stall on memory. It also adds byte, halfword and word accesses with sign/zero extension, error reporting, and a small memory-mapped I/O region (cycle counter, output port). It sits between the core's load/store unit and the RAM array, inside the system top level.

---
 rtl/dmem_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: request/ready handshake with LATENCY wait states,
// sized little-endian loads/stores, fault reporting and a two-word MMIO block.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] gpio_out
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] GPIO_ADDR = MMIO_BASE + 32'd4;
  localparam logic [2:0]  WAIT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_MMIO} src_t;

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic        acc_we_q, acc_we_d;
  logic [31:0] acc_addr_q, acc_addr_d;
  logic [31:0] acc_wdata_q, acc_wdata_d;
  logic [2:0]  acc_f3_q, acc_f3_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] mmio_q, mmio_d;
  src_t        src_q, src_d;
  logic        err_q, err_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_off_q, ld_off_d;

  logic        x_we;
  logic [31:0] x_addr;
  logic [31:0] x_wdata;
  logic [2:0]  x_f3;
  logic        commit;
  logic        sz_byte, sz_half, sz_word;
  logic        in_ram, is_cnt, is_gpio;
  logic        acc_err;
  logic        ram_we;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [AW-1:0] word_idx;
  logic [31:0] ram_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ram_fmt;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    acc_we_d    = acc_we_q;
    acc_addr_d  = acc_addr_q;
    acc_wdata_d = acc_wdata_q;
    acc_f3_d    = acc_f3_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          acc_we_d    = we;
          acc_addr_d  = addr;
          acc_wdata_d = wdata;
          acc_f3_d    = funct3;
          wait_d      = WAIT_INIT;
          state_d     = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_q == 3'd0) state_d = RESP;
        else                wait_d  = wait_q - 3'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access commits on the accept edge, so it must
  // be decoded from the live inputs rather than the capture registers.
  always_comb begin
    if (state_q == IDLE) begin
      x_we    = we;
      x_addr  = addr;
      x_wdata = wdata;
      x_f3    = funct3;
    end else begin
      x_we    = acc_we_q;
      x_addr  = acc_addr_q;
      x_wdata = acc_wdata_q;
      x_f3    = acc_f3_q;
    end
  end

  assign commit = reset && (state_d == RESP) && (state_q != RESP);

  always_comb begin
    sz_byte = (x_f3[1:0] == 2'b00);
    sz_half = (x_f3[1:0] == 2'b01);
    sz_word = (x_f3[1:0] == 2'b10);
    in_ram  = (x_addr < RAM_BYTES);
    is_cnt  = (x_addr == MMIO_BASE);
    is_gpio = (x_addr == GPIO_ADDR);
    acc_err = (x_f3 == 3'b011) || (x_f3[2:1] == 2'b11)
           || (x_we && x_f3[2])
           || (sz_half && x_addr[0])
           || (sz_word && (x_addr[1:0] != 2'b00))
           || !(in_ram || is_cnt || is_gpio)
           || (x_we && is_cnt)
           || ((is_cnt || is_gpio) && !sz_word);
  end

  always_comb begin
    be    = 4'b0000;
    wlane = x_wdata;
    if (sz_word) begin
      be = 4'b1111;
    end else if (sz_half) begin
      be    = x_addr[1] ? 4'b1100 : 4'b0011;
      wlane = {2{x_wdata[15:0]}};
    end else if (sz_byte) begin
      be    = 4'b0001 << x_addr[1:0];
      wlane = {4{x_wdata[7:0]}};
    end
  end

  assign ram_we   = commit && x_we && !acc_err && in_ram;
  assign word_idx = x_addr[AW+1:2];

  // One byte-wide array per lane keeps byte writes inferable as block RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] ram_lane [DEPTH_WORDS];
    logic [7:0] rd_lane_q;

    always_ff @(posedge clk) begin
      if (ram_we && be[gi]) ram_lane[word_idx] <= wlane[8*gi +: 8];
      if (commit)           rd_lane_q          <= ram_lane[word_idx];
    end

    assign ram_word[8*gi +: 8] = rd_lane_q;
  end

  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    gpio_d   = gpio_q;
    mmio_d   = mmio_q;
    src_d    = src_q;
    err_d    = err_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    if (commit) begin
      err_d    = acc_err;
      ld_f3_d  = x_f3;
      ld_off_d = x_addr[1:0];
      mmio_d   = is_cnt ? cycle_q : gpio_q;
      if (acc_err || x_we) src_d = SRC_ZERO;
      else if (in_ram)     src_d = SRC_RAM;
      else                 src_d = SRC_MMIO;
      if (x_we && !acc_err && is_gpio) gpio_d = x_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_q      <= 3'd0;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= 32'd0;
      acc_wdata_q <= 32'd0;
      acc_f3_q    <= 3'd0;
      cycle_q     <= 32'd0;
      gpio_q      <= 32'd0;
      mmio_q      <= 32'd0;
      src_q       <= SRC_ZERO;
      err_q       <= 1'b0;
      ld_f3_q     <= 3'd0;
      ld_off_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      acc_we_q    <= acc_we_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      acc_f3_q    <= acc_f3_d;
      cycle_q     <= cycle_d;
      gpio_q      <= gpio_d;
      mmio_q      <= mmio_d;
      src_q       <= src_d;
      err_q       <= err_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
    end
  end

  // Lane select and extension happen after the registered RAM read.
  always_comb begin
    ld_byte = ram_word[8*ld_off_q +: 8];
    ld_half = ld_off_q[1] ? ram_word[31:16] : ram_word[15:0];
    case (ld_f3_q[1:0])
      2'b00:   ram_fmt = {{24{!ld_f3_q[2] && ld_byte[7]}}, ld_byte};
      2'b01:   ram_fmt = {{16{!ld_f3_q[2] && ld_half[15]}}, ld_half};
      default: ram_fmt = ram_word;
    endcase
    case (src_q)
      SRC_RAM:  rdata = ram_fmt;
      SRC_MMIO: rdata = mmio_q;
      default:  rdata = 32'd0;
    endcase
  end

  assign ready    = (state_q == RESP);
  assign err      = err_q;
  assign gpio_out = gpio_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomised scoreboard bench for dmem_ctrl: a byte-array reference model
// predicts each response; a negedge monitor pops and compares on ready.
module tb_dmem_ctrl;
  localparam int          D    = 64;
  localparam int          LAT  = 1;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0, req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rdata, gpio_out;
  logic        ready, err;

  logic        reset3 = 1'b0, req3 = 1'b0, we3 = 1'b0;
  logic [31:0] addr3 = 32'd0, wdata3 = 32'd0;
  logic [2:0]  funct3_3 = 3'd0;
  logic [31:0] rdata3, gpio3;
  logic        ready3, err3;

  dmem_ctrl #(.DEPTH_WORDS(D), .LATENCY(LAT), .MMIO_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .funct3(funct3), .rdata(rdata), .ready(ready), .err(err), .gpio_out(gpio_out));

  dmem_ctrl #(.DEPTH_WORDS(D), .LATENCY(3), .MMIO_BASE(BASE)) dut3 (
    .clk(clk), .reset(reset3), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .funct3(funct3_3), .rdata(rdata3), .ready(ready3), .err(err3), .gpio_out(gpio3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: RAM as a byte array, counter as cycles since reset.
  logic [7:0]  mem_m [4*D];
  logic [31:0] gpio_m = 32'd0;
  logic [31:0] cyc_m  = 32'd0;
  always @(posedge clk) cyc_m <= (!reset) ? 32'd0 : cyc_m + 32'd1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] gpio;
  } exp_t;
  exp_t exp_q[$];

  function automatic void model(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, output bit e, output logic [31:0] rd);
    int          n;
    bit          bad, in_ram, is_c, is_g;
    longint      v;
    int unsigned base_i;
    n      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad    = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (w && f3[2]) || (a % n != 0);
    in_ram = a < 4 * D;
    is_c   = (a == BASE);
    is_g   = (a == BASE + 32'd4);
    if (!in_ram && !is_c && !is_g) bad = 1;
    if ((is_c || is_g) && n != 4)  bad = 1;
    if (w && is_c)                 bad = 1;
    rd = 32'd0;
    e  = bad;
    if (bad) return;
    base_i = a;
    if (w) begin
      if (is_g) gpio_m = wd;
      else for (int i = 0; i < n; i++) mem_m[base_i + i] = wd[8*i +: 8];
    end else if (is_c) begin
      rd = 32'(cyc_m + LAT);
    end else if (is_g) begin
      rd = gpio_m;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(mem_m[base_i + i]) << (8 * i));
      if (!f3[2] && n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
      rd = 32'(v);
    end
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        x = exp_q.pop_front();
        check("err", 32'(err), 32'(x.err));
        check("rdata", rdata, x.rdata);
        check("gpio_out", gpio_out, x.gpio);
      end
    end
  end

  logic [31:0] last_rd;
  logic        last_err;

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    exp_t x;
    bit   e;
    logic [31:0] rd;
    int   k;
    model(w, a, wd, f3, e, rd);
    x.err = e; x.rdata = rd; x.gpio = gpio_m;
    exp_q.push_back(x);
    req = 1'b1; we = w; addr = a; wdata = wd; funct3 = f3;
    @(negedge clk);
    req = 1'b0;
    k = 1;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: no ready within %0d cycles for addr %08h", k, a);
      void'(exp_q.pop_back());
    end else begin
      check("latency", 32'(k), 32'(LAT + 1));
    end
    last_rd  = rdata;
    last_err = err;
    $display("access we=%0d f3=%0d addr=%08h wdata=%08h -> err=%0d rdata=%08h",
             w, f3, a, wd, err, rdata);
    @(negedge clk);
  endtask

  task automatic access3(input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output logic [31:0] rd, output bit seen);
    int k;
    req3 = 1'b1; we3 = w; addr3 = a; wdata3 = wd; funct3_3 = f3;
    @(negedge clk);
    req3 = 1'b0;
    k = 1;
    while (!ready3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    seen = ready3;
    rd   = rdata3;
    $display("access3 we=%0d addr=%08h wdata=%08h -> ready=%0d rdata=%08h", w, a, wd, ready3, rdata3);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c0, c1, rd3, a;
    bit          seen, saw_ready;
    int          sel;

    repeat (3) @(negedge clk);
    reset = 1'b1; reset3 = 1'b1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_gpio", gpio_out, 32'd0);

    for (int w = 0; w < D; w++) access(1, 32'(4 * w), $urandom, 3'd2);

    access(1, 32'h10, 32'hDEADBEEF, 3'd2);
    access(0, 32'h10, 32'd0, 3'd2);
    check("lw_deadbeef", last_rd, 32'hDEADBEEF);
    access(1, 32'h10, 32'h8070F0FF, 3'd2);
    access(0, 32'h10, 32'd0, 3'd0);  check("lb_10", last_rd, 32'hFFFFFFFF);
    access(0, 32'h11, 32'd0, 3'd4);  check("lbu_11", last_rd, 32'h000000F0);
    access(0, 32'h12, 32'd0, 3'd1);  check("lh_12", last_rd, 32'hFFFF8070);
    access(0, 32'h12, 32'd0, 3'd5);  check("lhu_12", last_rd, 32'h00008070);
    access(1, 32'h13, 32'h12345655, 3'd0);
    access(0, 32'h10, 32'd0, 3'd2);  check("sb_13", last_rd, 32'h5570F0FF);
    access(1, 32'h10, 32'hAAAA1234, 3'd1);
    access(0, 32'h10, 32'd0, 3'd2);  check("sh_10", last_rd, 32'h55701234);

    access(0, 32'h11, 32'd0, 3'd2);           check("err_lw_11", 32'(last_err), 32'd1);
    access(1, 32'h21, 32'hFFFF, 3'd1);        check("err_sh_21", 32'(last_err), 32'd1);
    access(1, 32'h10, 32'h1, 3'd3);           check("err_f3_011", 32'(last_err), 32'd1);
    access(1, 32'(4 * D), 32'h1, 3'd2);       check("err_oob", 32'(last_err), 32'd1);
    access(1, BASE, 32'h1, 3'd2);             check("err_st_cnt", 32'(last_err), 32'd1);
    access(0, 32'h10, 32'd0, 3'd2);           check("ram_unchanged", last_rd, 32'h55701234);

    access(1, BASE + 32'd4, 32'hA5, 3'd2);    check("gpio_a5", gpio_out, 32'hA5);
    access(0, BASE + 32'd4, 32'd0, 3'd2);
    access(0, BASE, 32'd0, 3'd2);
    c0 = last_rd;
    repeat (10 - (LAT + 2)) @(negedge clk);
    access(0, BASE, 32'd0, 3'd2);
    c1 = last_rd;
    check("cnt_delta", c1 - c0, 32'd10);
    access(1, BASE + 32'd4, 32'h5A, 3'd0);    check("err_sb_gpio", 32'(last_err), 32'd1);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, 4 * D - 1));
      else if (sel == 7) a = 32'(4 * D + $urandom_range(0, 63));
      else if (sel == 8) a = BASE + 32'($urandom_range(0, 7));
      else               a = $urandom;
      access(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
    end

    access3(1, 32'h20, 32'h11111111, 3'd2, rd3, seen);
    check("l3_store_ready", 32'(seen), 32'd1);
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h20; wdata3 = 32'h22222222; funct3_3 = 3'd2;
    @(negedge clk);
    req3 = 1'b0; reset3 = 1'b0;
    @(negedge clk);
    reset3 = 1'b1;
    check("l3_rst_rdata", rdata3, 32'd0);
    saw_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ready3) saw_ready = 1'b1;
    end
    check("l3_no_ready", 32'(saw_ready), 32'd0);
    access3(0, 32'h20, 32'd0, 3'd2, rd3, seen);
    check("l3_load_ready", 32'(seen), 32'd1);
    check("l3_old_value", rd3, 32'h11111111);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
